// File: rtl/ram_dual_req_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | ram_dual_req_arbiter_pkg: shared widths and pointer encoding        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package ram_dual_req_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DATA_W = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_dual_req_arbiter_ram.sv
// +--------------------------------------------------------------------+
// | ram_single_port: 64x8 RAM, one write and one registered read/cycle  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module ram_single_port #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Read returns the pre-write contents on an address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/ram_dual_req_arbiter.sv
// +--------------------------------------------------------------------+
// | ram_dual_req_arbiter: two requesters share one RAM, independent     |
// | round-robin read/write arbitration with write-first forwarding      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module ram_dual_req_arbiter
  import ram_dual_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata
);

  logic              r_wpri;
  logic              r_rpri;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              r_fwd;
  logic [DATA_W-1:0] r_fwd_data;
  logic [DATA_W-1:0] r_hold;

  logic              w_wr_req0, w_wr_req1, w_rd_req0, w_rd_req1;
  logic              w_wr_gnt0, w_wr_gnt1, w_rd_gnt0, w_rd_gnt1;
  logic              w_ram_we;
  logic              w_rd_any;
  logic              w_fwd_hit;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ram_q;
  logic [DATA_W-1:0] w_rdata;

  always_comb begin
    w_wr_req0 = ~rst & req0 &  we0;
    w_wr_req1 = ~rst & req1 &  we1;
    w_rd_req0 = ~rst & req0 & ~we0;
    w_rd_req1 = ~rst & req1 & ~we1;

    // A lone requester always wins; the pointer only breaks ties.
    w_wr_gnt0 = w_wr_req0 & (~w_wr_req1 | (r_wpri == PORT0));
    w_wr_gnt1 = w_wr_req1 & (~w_wr_req0 | (r_wpri == PORT1));
    w_rd_gnt0 = w_rd_req0 & (~w_rd_req1 | (r_rpri == PORT0));
    w_rd_gnt1 = w_rd_req1 & (~w_rd_req0 | (r_rpri == PORT1));

    w_ram_we  = w_wr_gnt0 | w_wr_gnt1;
    w_rd_any  = w_rd_gnt0 | w_rd_gnt1;
    w_waddr   = w_wr_gnt1 ? addr1  : addr0;
    w_wdata   = w_wr_gnt1 ? wdata1 : wdata0;
    w_raddr   = w_rd_gnt1 ? addr1  : addr0;
    w_fwd_hit = w_ram_we & w_rd_any & (w_waddr == w_raddr);
  end

  assign gnt0 = w_wr_gnt0 | w_rd_gnt0;
  assign gnt1 = w_wr_gnt1 | w_rd_gnt1;

  ram_single_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wpri     <= PORT0;
      r_rpri     <= PORT0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
      r_hold     <= '0;
    end else begin
      if (w_wr_req0 & w_wr_req1) begin
        r_wpri <= ~r_wpri;
      end
      if (w_rd_req0 & w_rd_req1) begin
        r_rpri <= ~r_rpri;
      end
      r_rvalid0 <= w_rd_gnt0;
      r_rvalid1 <= w_rd_gnt1;
      r_fwd     <= w_fwd_hit;
      if (w_fwd_hit) begin
        r_fwd_data <= w_wdata;
      end
      r_hold <= w_rdata;
    end
  end

  // The RAM output moves with every read address, so idle cycles show the held value.
  always_comb begin
    w_rdata = r_hold;
    if (r_rvalid0 | r_rvalid1) begin
      w_rdata = r_fwd ? r_fwd_data : w_ram_q;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = w_rdata;

endmodule

`default_nettype wire
